// File: rtl/dut_run_host_if.sv
// Processor start/done handshake, data-memory read port and dump stream
// bundled between the run host (master) and its processor/memory/sink side.
interface dut_run_host_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output start, mem_addr, mem_rd_en, out_valid, out_data,
    input  done, mem_rdata, out_ready
  );

  modport slave (
    input  start, mem_addr, mem_rd_en, out_valid, out_data,
    output done, mem_rdata, out_ready
  );
endinterface

// File: rtl/dut_run_host.sv
// Host-side run sequencer: pulses start, times the processor until done,
// then reads a window of data memory and streams it out word by word.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for go; status outputs hold the last run's result
// START    | start held high for START_CYCLES cycles; done ignored
// RUN      | counting cycles until done or timeout
// DUMP_REQ | read strobe for word base+idx
// DUMP_CAP | memory data returning, latched into out_data
// DUMP_OUT | out_valid high until the sink takes the word
// FINISH   | one-cycle finished pulse, then back to IDLE
module dut_run_host #(
  parameter int AW           = 8,
  parameter int DW           = 8,
  parameter int CW           = 16,
  parameter int START_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             go,
  input  logic [AW-1:0]    rd_base,
  input  logic [AW:0]      rd_len,
  input  logic [CW-1:0]    max_cycles,
  dut_run_host_if.master   bus,
  output logic             busy,
  output logic [CW-1:0]    run_cycles,
  output logic             timed_out,
  output logic             finished
);

  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DUMP_REQ,
    DUMP_CAP,
    DUMP_OUT,
    FINISH
  } state_t;

  state_t        state;
  logic [AW-1:0] base_q;
  logic [AW:0]   len_q;
  logic [CW-1:0] max_q;
  logic [AW:0]   idx;
  logic [SW-1:0] start_cnt;
  logic [AW:0]   idx_nxt;

  assign idx_nxt = idx + (AW+1)'(1);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      base_q        <= '0;
      len_q         <= '0;
      max_q         <= '0;
      idx           <= '0;
      start_cnt     <= '0;
      bus.start     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      busy          <= 1'b0;
      run_cycles    <= '0;
      timed_out     <= 1'b0;
      finished      <= 1'b0;
    end else begin
      bus.mem_rd_en <= 1'b0;
      finished      <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            base_q     <= rd_base;
            len_q      <= rd_len;
            max_q      <= max_cycles;
            idx        <= '0;
            run_cycles <= '0;
            timed_out  <= 1'b0;
            start_cnt  <= SW'(START_CYCLES - 1);
            bus.start  <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          if (start_cnt == '0) begin
            bus.start <= 1'b0;
            state     <= RUN;
          end else begin
            start_cnt <= start_cnt - SW'(1);
          end
        end
        RUN: begin
          // done is checked first so a simultaneous timeout never wins
          if (bus.done) begin
            if (len_q != '0) begin
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= base_q;
              state         <= DUMP_REQ;
            end else begin
              finished <= 1'b1;
              state    <= FINISH;
            end
          end else if (max_q != '0 && run_cycles == max_q - CW'(1)) begin
            timed_out <= 1'b1;
            finished  <= 1'b1;
            state     <= FINISH;
          end else if (run_cycles != '1) begin
            run_cycles <= run_cycles + CW'(1);
          end
        end
        DUMP_REQ: begin
          state <= DUMP_CAP;
        end
        DUMP_CAP: begin
          bus.out_data  <= bus.mem_rdata;
          bus.out_valid <= 1'b1;
          state         <= DUMP_OUT;
        end
        DUMP_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            idx           <= idx_nxt;
            if (idx_nxt == len_q) begin
              finished <= 1'b1;
              state    <= FINISH;
            end else begin
              bus.mem_rd_en <= 1'b1;
              bus.mem_addr  <= base_q + idx_nxt[AW-1:0];
              state         <= DUMP_REQ;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_run_host.sv
// Bench for dut_run_host: directed and random runs against a processor,
// memory and stream-sink model, with results predicted from the run rules.
module tb_dut_run_host;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int CW = 16;
  localparam int START_CYCLES = 2;

  logic          CLK;
  logic          reset_n;
  logic          go;
  logic [AW-1:0] rd_base;
  logic [AW:0]   rd_len;
  logic [CW-1:0] max_cycles;
  logic          busy;
  logic [CW-1:0] run_cycles;
  logic          timed_out;
  logic          finished;

  logic [DW-1:0] mem [256];

  int n_vec = 0;
  int n_err = 0;

  dut_run_host_if #(.AW(AW), .DW(DW)) bus ();

  dut_run_host #(
    .AW(AW), .DW(DW), .CW(CW), .START_CYCLES(START_CYCLES)
  ) u_dut (
    .CLK        (CLK),
    .reset_n    (reset_n),
    .go         (go),
    .rd_base    (rd_base),
    .rd_len     (rd_len),
    .max_cycles (max_cycles),
    .bus        (bus),
    .busy       (busy),
    .run_cycles (run_cycles),
    .timed_out  (timed_out),
    .finished   (finished)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // synchronous-read data memory: data valid the cycle after the strobe
  always @(posedge CLK) begin
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete run. The processor raises done d RUN cycles after start
  // falls (never, if d is huge) and keeps it high afterwards.
  task automatic do_run(input logic [7:0] base, input logic [8:0] len, input logic [15:0] maxc,
                        input int d, input int rmode, input bit inject_go, input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] exp_a[$];
    int         exp_rc;
    bit         exp_to;
    int         start_hi;
    int         run_idx;
    bit         seen_start;
    bit         fin_seen;
    bit         pend;
    bit         hold_err;
    logic [7:0] pend_data;
    logic [7:0] a;
    logic       r;
    logic [8:0] g;

    start_hi = 0; run_idx = 0; seen_start = 0; fin_seen = 0;
    pend = 0; hold_err = 0; pend_data = '0;

    if (maxc == 0 || d < int'(maxc)) begin
      exp_rc = d;
      exp_to = 1'b0;
      for (int i = 0; i < int'(len); i++) begin
        a = base + 8'(i);
        exp_a.push_back(a);
        exp_q.push_back(mem[a]);
      end
    end else begin
      exp_rc = int'(maxc) - 1;
      exp_to = 1'b1;
    end

    @(negedge CLK);
    rd_base = base; rd_len = len; max_cycles = maxc; go = 1'b1; bus.out_ready = 1'b0;
    @(negedge CLK);
    go = 1'b0;
    rd_base = 8'($urandom); rd_len = 9'($urandom); max_cycles = 16'($urandom);
    check_val({tag, ":busy_run"}, 32'(busy), 32'd1);

    for (int c = 0; c < 3000 && !fin_seen; c++) begin
      if (bus.start) begin
        start_hi++;
        seen_start = 1'b1;
      end else if (seen_start) begin
        bus.done = (run_idx >= d);
        run_idx++;
      end
      go = inject_go && (run_idx == 3);
      if (bus.mem_rd_en) addr_q.push_back(bus.mem_addr);
      if (pend && (!bus.out_valid || bus.out_data !== pend_data)) hold_err = 1'b1;
      case (rmode)
        0:       r = 1'b1;
        1:       r = ~bus.out_ready;
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      pend = 1'b0;
      if (bus.out_valid) begin
        if (r) got_q.push_back(bus.out_data);
        else begin
          pend = 1'b1;
          pend_data = bus.out_data;
        end
      end
      if (finished) fin_seen = 1'b1;
      @(negedge CLK);
    end
    go = 1'b0;

    check_val({tag, ":finished_seen"}, 32'(fin_seen), 32'd1);
    check_val({tag, ":finished_pulse"}, 32'(finished), 32'd0);
    check_val({tag, ":busy_idle"}, 32'(busy), 32'd0);
    check_val({tag, ":start_cycles"}, 32'(start_hi), 32'(START_CYCLES));
    check_val({tag, ":run_cycles"}, 32'(run_cycles), 32'(exp_rc));
    check_val({tag, ":timed_out"}, 32'(timed_out), 32'(exp_to));
    check_val({tag, ":n_reads"}, 32'(addr_q.size()), 32'(exp_a.size()));
    check_val({tag, ":n_words"}, 32'(got_q.size()), 32'(exp_q.size()));
    check_val({tag, ":held"}, 32'(hold_err), 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? {1'b0, got_q[i]} : 9'h100;
      check_val($sformatf("%s:word%0d", tag, i), 32'(g), 32'(exp_q[i]));
      g = (i < addr_q.size()) ? {1'b0, addr_q[i]} : 9'h100;
      check_val($sformatf("%s:addr%0d", tag, i), 32'(g), 32'(exp_a[i]));
    end
  endtask

  initial begin
    logic [15:0] mc;
    bit          reached;

    reset_n = 1'b1; go = 1'b0; rd_base = '0; rd_len = '0; max_cycles = '0;
    bus.done = 1'b0; bus.out_ready = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h40] = 8'h11; mem[8'h41] = 8'h22; mem[8'h42] = 8'h33;

    #3 reset_n = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst:start", 32'(bus.start), 32'd0);
    check_val("rst:mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check_val("rst:out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst:busy", 32'(busy), 32'd0);
    check_val("rst:finished", 32'(finished), 32'd0);
    check_val("rst:timed_out", 32'(timed_out), 32'd0);
    check_val("rst:run_cycles", 32'(run_cycles), 32'd0);
    check_val("rst:mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("rst:out_data", 32'(bus.out_data), 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge CLK);

    do_run(8'h40, 9'd3, 16'd0, 10, 0, 1'b0, "basic");
    bus.done = 1'b1;
    do_run(8'h10, 9'd2, 16'd0, 7, 0, 1'b0, "stale");
    do_run(8'h20, 9'd3, 16'd5, 100000, 0, 1'b0, "timeout");
    do_run(8'hFE, 9'd4, 16'd0, 3, 1, 1'b0, "wrap");
    do_run(8'h33, 9'd0, 16'd0, 4, 0, 1'b0, "len0");
    do_run(8'h80, 9'd256, 16'd0, 2, 0, 1'b0, "len256");
    do_run(8'h05, 9'd2, 16'd8, 7, 2, 1'b0, "done_tie");
    do_run(8'h06, 9'd1, 16'd1, 0, 0, 1'b0, "tie_max1");
    do_run(8'h07, 9'd2, 16'd6, 6, 0, 1'b0, "timeout_edge");
    do_run(8'h50, 9'd3, 16'd0, 12, 2, 1'b1, "go_ignored");

    for (int k = 0; k < 12; k++) begin
      mc = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
      do_run(8'($urandom), 9'($urandom_range(0, 12)), mc, int'($urandom_range(0, 30)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
    end

    // abort in the middle of a dump with the sink stalled
    bus.done = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge CLK);
    rd_base = 8'h10; rd_len = 9'd5; max_cycles = 16'd0; go = 1'b1;
    @(negedge CLK);
    go = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 100 && !reached; c++) begin
      if (bus.out_valid) reached = 1'b1;
      else @(negedge CLK);
    end
    check_val("arst:reach_dump", 32'(reached), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_val("arst:start", 32'(bus.start), 32'd0);
    check_val("arst:mem_rd_en", 32'(bus.mem_rd_en), 32'd0);
    check_val("arst:out_valid", 32'(bus.out_valid), 32'd0);
    check_val("arst:busy", 32'(busy), 32'd0);
    check_val("arst:finished", 32'(finished), 32'd0);
    check_val("arst:run_cycles", 32'(run_cycles), 32'd0);
    check_val("arst:mem_addr", 32'(bus.mem_addr), 32'd0);
    check_val("arst:out_data", 32'(bus.out_data), 32'd0);
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    bus.done = 1'b0;
    @(negedge CLK);
    do_run(8'hC0, 9'd3, 16'd20, 5, 2, 1'b1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dut_run_host.md
Name: dut_run_host

Overview:
- Host-side initiator for the processor's start/done handshake.
- On a `go` pulse it:
  - asserts `start` to the processor for a programmed number of cycles;
  - counts cycles until the processor raises `done`, with an optional timeout;
  - reads back a window of data memory through a read port;
  - streams the bytes out on a valid/ready interface.
- It sits beside the processor top level in the FPGA/sim harness and replaces hand-driven start/done sequencing.

Parameters:
- AW, 8, data memory address width.
- DW, 8, data memory word width.
- CW, 16, cycle counter and timeout width.
- START_CYCLES, 2, number of cycles `start` is held high (must be ≥1).

Ports:
- CLK  in  1  clock, posedge.
- reset_n  in  1  asynchronous active-low reset.
- go  in  1  single-cycle request to begin a run; sampled in IDLE only.
- rd_base  in  AW  first data-memory address to dump; captured on accepted `go`.
- rd_len  in  AW+1  number of words to dump (0 to 2^AW); captured on accepted `go`.
- max_cycles  in  CW  timeout limit; 0 disables timeout; captured on accepted `go`.
- start  out  1  processor init/reset, active high.
- done  in  1  processor done flag.
- mem_addr  out  AW  data memory read address.
- mem_rd_en  out  1  read strobe.
- mem_rdata  in  DW  read data, valid exactly one cycle after `mem_rd_en`.
- out_valid  out  1  dump stream valid.
- out_data  out  DW  dump stream data.
- out_ready  in  1  dump stream ready.
- busy  out  1  high in every state except IDLE.
- run_cycles  out  CW  cycles counted in RUN; held until next accepted `go`.
- timed_out  out  1  set if RUN ended by timeout; held until next accepted `go`.
- finished  out  1  one-cycle pulse on FINISH→IDLE.

Behaviour:
- **Reset (`reset_n` low, async):**
  - State goes to IDLE.
  - These outputs go to 0: `start`, `mem_rd_en`, `out_valid`, `busy`, `finished`, `timed_out`, `run_cycles`, `mem_addr`, `out_data`.
  - `start` is NOT asserted by `reset_n`.
  - Reset mid-run aborts immediately; no partial dump completes.
- **IDLE:**
  - `go`=1 captures `rd_base`, `rd_len` and `max_cycles`, clears `run_cycles` and `timed_out`, and moves to START.
  - `go` in any other state is ignored.
- **START:**
  - `start`=1 for exactly START_CYCLES cycles, then RUN.
  - `done` is ignored in START, because it may still be high from a previous run.
- **RUN:**
  - `start`=0.
  - `run_cycles` increments every cycle in RUN, saturating at all-ones.
  - Exit on `done` sampled high: go to DUMP_REQ if `rd_len`≠0, otherwise FINISH. `run_cycles` equals the number of RUN cycles before the one where `done` was seen.
  - Timeout: when `max_cycles`≠0 and `run_cycles`==`max_cycles`-1 without `done`, set `timed_out`=1, go to FINISH, and skip the dump.
  - `done` and timeout in the same cycle: `done` wins and `timed_out` stays 0.
- **DUMP_REQ:**
  - `mem_rd_en`=1 for one cycle with `mem_addr`=base+idx, mod 2^AW (wraps past top of memory).
  - Next state is DUMP_CAP.
- **DUMP_CAP:**
  - Latch `mem_rdata` into `out_data`, set `out_valid`=1, then DUMP_OUT.
- **DUMP_OUT:**
  - `out_valid` and `out_data` are held stable until `out_valid`&`out_ready`.
  - On handshake, `out_valid` drops the next cycle and idx increments.
  - If idx reaches `rd_len`, go to FINISH; otherwise DUMP_REQ.
  - Throughput is at most one word per 3 cycles.
  - `out_valid` never asserts outside DUMP_OUT.
- **FINISH:**
  - `finished`=1 for one cycle, then IDLE, with `busy`=0 from that cycle.
- **Widths:** idx is AW+1 bits so that `rd_len`=2^AW works.

Test Plan:
- Basic run: reset, `go` with `rd_base`=0x40, `rd_len`=3, `max_cycles`=0; processor model raises `done` after 10 RUN cycles; memory holds 0x11,0x22,0x33 at 0x40–0x42; `out_ready`=1 → `start` high exactly 2 cycles, `run_cycles`=10, stream 0x11,0x22,0x33, then `finished` pulse, `timed_out`=0.
- Stale done: `done` held high before and during START, and the model clears it only after `start` → `done` is not sampled until RUN; `run_cycles` reflects the second rise of `done`.
- Timeout: `max_cycles`=5 and `done` never rises → `timed_out`=1, `run_cycles`=4, no `mem_rd_en`, `finished` pulses.
- Backpressure and wrap: `rd_base`=0xFE, `rd_len`=4, `out_ready` toggling 0/1 → addresses FE,FF,00,01; each word is held stable while `out_ready`=0, and no word is lost or duplicated.
- Edge lengths: `rd_len`=0 → no reads, FINISH right after `done`; `rd_len`=256 → 256 words delivered.
- Async reset: `reset_n` pulled low mid-DUMP_OUT → all outputs are 0 immediately; a later `go` runs cleanly, and `go` during a busy run is ignored.
